// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense controller.
package vend_pkg;

   localparam int CREDIT_W = 4;

   // Coin values in farthings, as seen by the upstream accumulator.
   localparam int FARTHING = 1;
   localparam int HAPENNY  = 2;
   localparam int PENNY    = 4;

   typedef logic [CREDIT_W-1:0] credit_t;

   typedef enum logic [1:0] {IDLE, VEND, CHANGE, CLEAR} vend_state_t;

endpackage

// File: rtl/vend_dispense_ctrl_if.sv
// Credit/refund inputs and dispense outputs between the accumulator side and the controller.
interface vend_dispense_ctrl_if;
   import vend_pkg::*;

   credit_t credit;
   logic    refund;
   logic    vend;
   logic    chg_pulse;
   logic    clr_req;
   logic    busy;

   modport master (output credit, refund, input vend, chg_pulse, clr_req, busy);
   modport slave  (input credit, refund, output vend, chg_pulse, clr_req, busy);

endinterface

// File: rtl/vend_credit_sync.sv
// Two-flop synchroniser for the credit bus plus a one-cycle stability compare.
module vend_credit_sync
   import vend_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  credit_t credit,
   output credit_t cred_s,
   output logic    cred_ok
);

   credit_t meta, prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta   <= '0;
         cred_s <= '0;
         prev   <= '0;
      end else begin
         meta   <= credit;
         cred_s <= meta;
         prev   <= cred_s;
      end
   end

   // Bits that land on different cycles never look stable for two samples.
   assign cred_ok = (cred_s == prev);

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Vend/change/clear sequencer on CLK50M. Define VEND_CHANGE_EN to build the change payout path.
module vend_dispense_ctrl
   import vend_pkg::*;
#(
   parameter int PRICE    = 6,
   parameter int VEND_CYC = 4,
   parameter int CHG_GAP  = 3
) (
   input  logic              CLK50M,
   input  logic              RSTb,
   vend_dispense_ctrl_if.slave bus
);

   localparam credit_t PRICE_C = credit_t'(PRICE);
   localparam int      VT_W    = $clog2(VEND_CYC + 1);

   logic        rst_meta, rst_n;
   credit_t     cred_s;
   logic        cred_ok;
   logic [2:0]  rf_q;
   logic        rf_rise, go_vend, go_ref;
   vend_state_t state;
   logic [VT_W-1:0] vtmr;
   logic        vend_q, clr_q, busy_q;

   // Reset drops everything at once but releases on a clock edge.
   always_ff @(posedge CLK50M or negedge RSTb) begin
      if (!RSTb) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   vend_credit_sync u_sync (
      .clk     (CLK50M),
      .rst_n   (rst_n),
      .credit  (bus.credit),
      .cred_s  (cred_s),
      .cred_ok (cred_ok)
   );

   always_ff @(posedge CLK50M or negedge rst_n) begin
      if (!rst_n) rf_q <= '0;
      else        rf_q <= {rf_q[1:0], bus.refund};
   end

   assign rf_rise = rf_q[1] & ~rf_q[2];
   assign go_vend = cred_ok && (cred_s >= PRICE_C);
   assign go_ref  = rf_rise && cred_ok && (cred_s != '0);

`ifdef VEND_CHANGE_EN
   localparam int GP_W = $clog2(CHG_GAP + 1);

   credit_t         chg_amt;
   logic [GP_W-1:0] gap;
   logic            chg_q;

   always_ff @(posedge CLK50M or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         vtmr    <= '0;
         vend_q  <= 1'b0;
         clr_q   <= 1'b0;
         busy_q  <= 1'b0;
         chg_q   <= 1'b0;
         chg_amt <= '0;
         gap     <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Vend takes priority over a refund edge in the same cycle.
               if (go_vend) begin
                  state   <= VEND;
                  vend_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  vtmr    <= VT_W'(VEND_CYC - 1);
                  chg_amt <= cred_s - PRICE_C;
               end else if (go_ref) begin
                  state   <= CHANGE;
                  busy_q  <= 1'b1;
                  chg_q   <= 1'b1;
                  chg_amt <= cred_s - credit_t'(1);
                  gap     <= GP_W'(CHG_GAP);
               end
            end
            VEND: begin
               if (vtmr == '0) begin
                  vend_q <= 1'b0;
                  if (chg_amt != '0) begin
                     state   <= CHANGE;
                     chg_q   <= 1'b1;
                     chg_amt <= chg_amt - credit_t'(1);
                     gap     <= GP_W'(CHG_GAP);
                  end else begin
                     state <= CLEAR;
                     clr_q <= 1'b1;
                  end
               end else begin
                  vtmr <= vtmr - VT_W'(1);
               end
            end
            CHANGE: begin
               // chg_amt counts pulses still owed after the one on the wire.
               if (gap != '0) begin
                  gap   <= gap - GP_W'(1);
                  chg_q <= 1'b0;
               end else if (chg_amt != '0) begin
                  chg_q   <= 1'b1;
                  chg_amt <= chg_amt - credit_t'(1);
                  gap     <= GP_W'(CHG_GAP);
               end else begin
                  state <= CLEAR;
                  clr_q <= 1'b1;
               end
            end
            CLEAR: begin
               if (cred_ok && cred_s == '0) begin
                  state  <= IDLE;
                  clr_q  <= 1'b0;
                  busy_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.chg_pulse = chg_q;
`else
   always_ff @(posedge CLK50M or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         vtmr   <= '0;
         vend_q <= 1'b0;
         clr_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (go_vend) begin
                  state  <= VEND;
                  vend_q <= 1'b1;
                  busy_q <= 1'b1;
                  vtmr   <= VT_W'(VEND_CYC - 1);
               end else if (go_ref) begin
                  // Without change payout a refund forfeits the credit.
                  state  <= CLEAR;
                  busy_q <= 1'b1;
                  clr_q  <= 1'b1;
               end
            end
            VEND: begin
               if (vtmr == '0) begin
                  state  <= CLEAR;
                  vend_q <= 1'b0;
                  clr_q  <= 1'b1;
               end else begin
                  vtmr <= vtmr - VT_W'(1);
               end
            end
            CLEAR: begin
               if (cred_ok && cred_s == '0) begin
                  state  <= IDLE;
                  clr_q  <= 1'b0;
                  busy_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.chg_pulse = 1'b0;
`endif

   assign bus.vend    = vend_q;
   assign bus.clr_req = clr_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: transaction table with scoreboard plus reset/skew/clear-hold sequences.
module tb_vend_dispense_ctrl;
   import vend_pkg::*;

`ifdef VEND_CHANGE_EN
   localparam bit CHG = 1'b1;
`else
   localparam bit CHG = 1'b0;
`endif

   typedef struct {
      int vruns;
      int vcyc;
      int pulses;
      int span;
      int clr;
   } exp_t;

   typedef struct {
      string nm;
      int    credit;
      int    rf_dly;
      exp_t  e;
   } vec_t;

   logic CLK50M = 1'b0;
   logic RSTb   = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   always #10 CLK50M = ~CLK50M;

   vend_dispense_ctrl_if bus ();

   vend_dispense_ctrl #(.PRICE(6), .VEND_CYC(4), .CHG_GAP(3)) dut (
      .CLK50M (CLK50M),
      .RSTb   (RSTb),
      .bus    (bus)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Drive one credit value (and optional refund edge), watch the whole busy window.
   task automatic run_txn(input string nm, input int cr, input int rf_dly, input exp_t e);
      int   n = 0, vc = 0, vr = 0, pc = 0, sp = 0, cl = 0, last_p = -1, bad_gap = 0;
      int   limit;
      bit   pv = 0, pp = 0, seen_busy = 0, done = 0;
      bit   v, p, b, c;
      exp_t got;
      sb.push_back(e);
      limit = (e.span == 0) ? 25 : 200;
      @(negedge CLK50M);
      bus.credit = credit_t'(cr);
      while (!done && n < limit) begin
         if (rf_dly >= 0 && n == rf_dly) bus.refund = 1'b1;
         @(negedge CLK50M);
         n++;
         v = bus.vend; p = bus.chg_pulse; b = bus.busy; c = bus.clr_req;
         if (v) vc++;
         if (v && !pv) vr++;
         if (p && !pp) begin
            pc++;
            if (last_p >= 0 && n - last_p != 4) bad_gap = 1;
            last_p = n;
         end
         if (p && pp) bad_gap = 1;
         if (b) begin sp++; seen_busy = 1; end
         if (c) cl = 1;
         if (c && bus.credit != '0) bus.credit = '0;
         if (seen_busy && !b) done = 1;
         pv = v; pp = p;
      end
      got = sb.pop_front();
      if (got.span != 0) chk({nm, " done"}, int'(done), 1);
      chk({nm, " vend_runs"}, vr, got.vruns);
      chk({nm, " vend_cycles"}, vc, got.vcyc);
      chk({nm, " chg_pulses"}, pc, got.pulses);
      chk({nm, " busy_span"}, sp, got.span);
      chk({nm, " clr_req"}, cl, got.clr);
      if (got.pulses >= 2) chk({nm, " pulse_gap_bad"}, bad_gap, 0);
      bus.refund = 1'b0;
      bus.credit = '0;
      repeat (6) @(negedge CLK50M);
   endtask

   initial begin
      vec_t tbl[9];
      int   w;
      tbl[0] = '{"exact6",   6, -1, '{1, 4, 0,           8,              1}};
      tbl[1] = '{"over9",    9, -1, '{1, 4, CHG ? 3 : 0, CHG ? 20 : 8,   1}};
      tbl[2] = '{"over15",  15, -1, '{1, 4, CHG ? 9 : 0, CHG ? 44 : 8,   1}};
      tbl[3] = '{"refund5",  5,  5, '{0, 0, CHG ? 5 : 0, CHG ? 24 : 4,   1}};
      tbl[4] = '{"refund0",  0,  3, '{0, 0, 0,           0,              0}};
      tbl[5] = '{"race7",    7,  1, '{1, 4, CHG ? 1 : 0, CHG ? 12 : 8,   1}};
      tbl[6] = '{"rf_busy",  9,  5, '{1, 4, CHG ? 3 : 0, CHG ? 20 : 8,   1}};
      tbl[7] = '{"under3",   3, -1, '{0, 0, 0,           0,              0}};
      tbl[8] = '{"refund1",  1,  5, '{0, 0, CHG ? 1 : 0, CHG ? 8 : 4,    1}};

      bus.credit = '0;
      bus.refund = 1'b0;
      RSTb = 1'b0;
      repeat (3) @(negedge CLK50M);
      chk("reset vend", int'(bus.vend), 0);
      chk("reset chg_pulse", int'(bus.chg_pulse), 0);
      chk("reset clr_req", int'(bus.clr_req), 0);
      chk("reset busy", int'(bus.busy), 0);
      RSTb = 1'b1;
      repeat (5) @(negedge CLK50M);

      for (int i = 0; i < 9; i++) run_txn(tbl[i].nm, tbl[i].credit, tbl[i].rf_dly, tbl[i].e);

      // Credit 3 -> 7 walking through 2 and 6 for one cycle each.
      bus.credit = credit_t'(3);
      repeat (6) @(negedge CLK50M);
      chk("skew idle busy", int'(bus.busy), 0);
      bus.credit = credit_t'(2);
      @(negedge CLK50M);
      bus.credit = credit_t'(6);
      run_txn("skew7", 7, -1, '{1, 4, CHG ? 1 : 0, CHG ? 12 : 8, 1});

      // clr_req holds while credit stays nonzero.
      bus.credit = credit_t'(6);
      w = 0;
      while (!bus.clr_req && w < 40) begin @(negedge CLK50M); w++; end
      chk("hold clr seen", int'(bus.clr_req), 1);
      repeat (40) @(negedge CLK50M);
      chk("hold clr_req", int'(bus.clr_req), 1);
      chk("hold busy", int'(bus.busy), 1);
      bus.credit = '0;
      repeat (6) @(negedge CLK50M);
      chk("hold released clr", int'(bus.clr_req), 0);
      chk("hold released busy", int'(bus.busy), 0);

      // Reset in the middle of a vend.
      bus.credit = credit_t'(6);
      w = 0;
      while (!bus.vend && w < 20) begin @(negedge CLK50M); w++; end
      chk("midrst vend seen", int'(bus.vend), 1);
      @(negedge CLK50M);
      RSTb = 1'b0;
      #1;
      chk("midrst vend", int'(bus.vend), 0);
      chk("midrst busy", int'(bus.busy), 0);
      chk("midrst clr_req", int'(bus.clr_req), 0);
      bus.credit = '0;
      repeat (3) @(negedge CLK50M);
      RSTb = 1'b1;
      repeat (10) @(negedge CLK50M);
      chk("midrst idle busy", int'(bus.busy), 0);
      chk("midrst idle vend", int'(bus.vend), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
